// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI burst write master: FSM states,
// burst/response encodings and the write-response timeout length.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int WR_TIMEOUT_CYC = 256;

  function automatic logic [2:0] axsize_for(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/wr_beat_counter.sv
// Remaining-beat down-counter for one write burst; last flags the final beat.
module wr_beat_counter (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       last
);

  logic [3:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/axi_burst_write_master.sv
// Single-outstanding AXI INCR burst write master with pass-through beat data.
// Optional B-channel timeout enabled by defining AXI_WR_BRESP_TIMEOUT_EN.
module axi_burst_write_master
  import axi_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [3:0]          req_len,
  input  logic [ID_W-1:0]     req_id,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic                rd_busy,
  output logic                done_valid,
  output logic [1:0]          done_resp,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int STRB_W = DATA_W / 8;

  wr_state_e           state_d, state_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [3:0]          len_d, len_q;
  logic [ID_W-1:0]     id_d, id_q;
  logic [STRB_W-1:0]   strb_d, strb_q;
  logic                done_valid_d, done_valid_q;
  logic [1:0]          done_resp_d, done_resp_q;
  logic                accept, w_fire, beat_last;
  logic                in_addr, in_data, in_resp;

`ifdef AXI_WR_BRESP_TIMEOUT_EN
  localparam int TMO_W = $clog2(WR_TIMEOUT_CYC);
  logic [TMO_W-1:0]    tmo_d, tmo_q;
`endif

  assign in_addr   = (state_q == ST_ADDR);
  assign in_data   = (state_q == ST_DATA);
  assign in_resp   = (state_q == ST_RESP);
  assign req_ready = (state_q == ST_IDLE) && !rd_busy;
  assign accept    = req_valid && req_ready;
  assign w_fire    = in_data && wd_valid && WREADY;

  wr_beat_counter u_beat_cnt (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .load     (accept),
    .load_val (req_len),
    .dec      (w_fire),
    .last     (beat_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    id_d         = id_q;
    strb_d       = strb_q;
    done_valid_d = 1'b0;
    done_resp_d  = RESP_OKAY;
`ifdef AXI_WR_BRESP_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          len_d   = req_len;
          id_d    = req_id;
          strb_d  = req_strb;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: if (AWREADY) state_d = ST_DATA;
      ST_DATA: begin
        if (w_fire && beat_last) begin
          state_d = ST_RESP;
`ifdef AXI_WR_BRESP_TIMEOUT_EN
          tmo_d   = TMO_W'(WR_TIMEOUT_CYC - 1);
`endif
        end
      end
      ST_RESP: begin
        if (BVALID) begin
          state_d      = ST_IDLE;
          done_valid_d = 1'b1;
          done_resp_d  = BRESP;
`ifdef AXI_WR_BRESP_TIMEOUT_EN
        end else if (tmo_q == '0) begin
          // Slave never answered: report the burst as failed rather than hang.
          state_d      = ST_IDLE;
          done_valid_d = 1'b1;
          done_resp_d  = RESP_SLVERR;
        end else begin
          tmo_d        = tmo_q - 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      strb_q       <= '0;
      done_valid_q <= 1'b0;
      done_resp_q  <= RESP_OKAY;
`ifdef AXI_WR_BRESP_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      id_q         <= id_d;
      strb_q       <= strb_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
`ifdef AXI_WR_BRESP_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign AWSIZE     = axsize_for(DATA_W);
  assign AWBURST    = BURST_INCR;
  assign AWVALID    = in_addr;
  assign AWID       = in_addr ? id_q   : '0;
  assign AWADDR     = in_addr ? addr_q : '0;
  assign AWLEN      = in_addr ? len_q  : '0;

  assign WVALID     = in_data && wd_valid;
  assign wd_ready   = in_data && WREADY;
  assign WDATA      = in_data ? wd_data : '0;
  assign WSTRB      = in_data ? strb_q  : '0;
  assign WLAST      = in_data && beat_last;

  assign BREADY     = in_resp;
  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master; the timeout scenario runs only
// when AXI_WR_BRESP_TIMEOUT_EN is defined.
module tb_axi_burst_write_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [7:0]  req_id;
  logic [3:0]  req_strb;
  logic [31:0] wd_data;
  logic        wd_valid, wd_ready, rd_busy;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  logic        r64_ready, wd64_ready, done64_valid;
  logic [1:0]  done64_resp, awburst64;
  logic [7:0]  awid64;
  logic [31:0] awaddr64;
  logic [3:0]  awlen64;
  logic [2:0]  awsize64;
  logic        awvalid64, wlast64, wvalid64, bready64;
  logic [63:0] wdata64;
  logic [7:0]  wstrb64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axi_burst_write_master #(.DATA_W(32), .ADDR_W(32), .ID_W(8)) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_id(req_id), .req_strb(req_strb),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_busy(rd_busy), .done_valid(done_valid), .done_resp(done_resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  axi_burst_write_master #(.DATA_W(64), .ADDR_W(32), .ID_W(8)) u_dut64 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(1'b0), .req_ready(r64_ready), .req_addr(32'h0),
    .req_len(4'h0), .req_id(8'h0), .req_strb(8'h0),
    .wd_data(64'h0), .wd_valid(1'b0), .wd_ready(wd64_ready),
    .rd_busy(1'b0), .done_valid(done64_valid), .done_resp(done64_resp),
    .AWID(awid64), .AWADDR(awaddr64), .AWLEN(awlen64), .AWSIZE(awsize64),
    .AWBURST(awburst64), .AWVALID(awvalid64), .AWREADY(1'b0),
    .WDATA(wdata64), .WSTRB(wstrb64), .WLAST(wlast64), .WVALID(wvalid64),
    .WREADY(1'b0), .BRESP(2'b00), .BVALID(1'b0), .BREADY(bready64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic [3:0] len,
                         input logic [7:0] id, input logic [3:0] strb);
    @(negedge ACLK);
    req_valid = 1'b1; req_addr = addr; req_len = len; req_id = id; req_strb = strb;
    #1;
    check("req_ready_idle", req_ready, 1'b1);
    check("awvalid_idle", AWVALID, 1'b0);
  endtask

  // Starts in the ADDR cycle following acceptance. b_delay < 0 means BVALID never comes.
  task automatic finish_burst(input logic [31:0] addr, input logic [3:0] len,
                              input logic [7:0] id, input logic [3:0] strb,
                              input int aw_wait, input bit wtog,
                              input int b_delay, input logic [1:0] bresp);
    int beats, cyc, k;
    logic [31:0] exp_data;
    @(negedge ACLK);
    // Request-side changes after acceptance must not disturb the burst.
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_len = 4'hF; req_id = 8'hFF; rd_busy = 1'b1;
    AWREADY = (aw_wait == 0); WREADY = 1'b1; wd_valid = 1'b1; wd_data = 32'h1234_5678;
    #1;
    check("awvalid", AWVALID, 1'b1);
    check("awaddr", AWADDR, addr);
    check("awlen", AWLEN, len);
    check("awid", AWID, id);
    check("awburst", AWBURST, 2'b01);
    check("wvalid_in_addr", WVALID, 1'b0);
    check("wd_ready_in_addr", wd_ready, 1'b0);
    for (int i = 0; i < aw_wait; i++) begin
      @(negedge ACLK);
      AWREADY = (i == aw_wait - 1);
      #1;
      check("awaddr_hold", AWADDR, addr);
      check("awvalid_hold", AWVALID, 1'b1);
    end
    beats = 0; cyc = 0;
    while (beats <= int'(len) && cyc < 100) begin
      @(negedge ACLK);
      AWREADY  = 1'b0;
      WREADY   = wtog ? cyc[0] : 1'b1;
      wd_valid = !(wtog && cyc == 3);
      exp_data = 32'hD000_0000 + beats;
      wd_data  = exp_data;
      #1;
      check("wvalid", WVALID, wd_valid);
      check("wdata", WDATA, exp_data);
      check("wstrb", WSTRB, strb);
      check("wlast", WLAST, beats == int'(len));
      check("wd_ready", wd_ready, WREADY);
      if (wd_valid && WREADY) beats++;
      cyc++;
    end
    check("w_beat_bound", cyc < 100, 1'b1);
    @(negedge ACLK);
    WREADY = 1'b1; wd_valid = 1'b1; rd_busy = 1'b0;
    BVALID = (b_delay == 0); BRESP = bresp;
    #1;
    check("no_extra_beat", WVALID, 1'b0);
    check("wd_ready_resp", wd_ready, 1'b0);
    check("bready", BREADY, 1'b1);
    if (b_delay >= 0) begin
      for (int i = 0; i < b_delay; i++) begin
        @(negedge ACLK);
        BVALID = (i == b_delay - 1);
        #1;
        check("bready_hold", BREADY, 1'b1);
        check("no_early_done", done_valid, 1'b0);
      end
      @(negedge ACLK);
      BVALID = 1'b0; WREADY = 1'b0; wd_valid = 1'b0;
      #1;
      check("done_valid", done_valid, 1'b1);
      check("done_resp", done_resp, bresp);
    end else begin
      k = 1;
      while (done_valid !== 1'b1 && k < 400) begin
        @(negedge ACLK);
        WREADY = 1'b0; wd_valid = 1'b0;
        #1;
        k++;
      end
      check("timeout_cycle", k, 257);
      check("timeout_resp", done_resp, 2'b10);
    end
    check("req_ready_at_done", req_ready, 1'b1);
    check("bready_after", BREADY, 1'b0);
    @(negedge ACLK);
    #1;
    check("done_one_cycle", done_valid, 1'b0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_id = '0;
    req_strb = '0; wd_data = '0; wd_valid = 1'b0; rd_busy = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_awvalid", AWVALID, 1'b0);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_bready", BREADY, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_done_resp", done_resp, 2'b00);
    check("rst_awaddr", AWADDR, 32'h0);
    check("awsize_32", AWSIZE, 3'b010);
    check("awsize_64", awsize64, 3'b011);
    ARESETn = 1'b1;

    // Basic 4-beat burst, AWREADY immediately high, OKAY response.
    request(32'h0000_1000, 4'd3, 8'h5A, 4'hF);
    finish_burst(32'h0000_1000, 4'd3, 8'h5A, 4'hF, 0, 1'b0, 0, 2'b00);

    // AWREADY low for 5 cycles, WREADY toggling with a client stall, delayed SLVERR.
    request(32'h2000_0040, 4'd5, 8'h11, 4'b0011);
    finish_burst(32'h2000_0040, 4'd5, 8'h11, 4'b0011, 5, 1'b1, 3, 2'b10);

    // Read master busy blocks acceptance until it drops.
    @(negedge ACLK);
    rd_busy = 1'b1; req_valid = 1'b1; req_addr = 32'h300; req_len = 4'd0;
    req_id = 8'h07; req_strb = 4'h1;
    #1;
    check("busy_req_ready", req_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      #1;
      check("busy_awvalid", AWVALID, 1'b0);
      check("busy_req_ready_hold", req_ready, 1'b0);
    end
    @(negedge ACLK);
    rd_busy = 1'b0;
    #1;
    check("unbusy_req_ready", req_ready, 1'b1);
    finish_burst(32'h300, 4'd0, 8'h07, 4'h1, 0, 1'b0, 0, 2'b01);

    // Reset in the middle of the data phase: back to idle, no completion pulse.
    request(32'h4000, 4'd7, 8'h22, 4'hF);
    @(negedge ACLK);
    req_valid = 1'b0; AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0; WREADY = 1'b1; wd_valid = 1'b1; wd_data = 32'hCAFE_0000;
    #1;
    check("mid_wvalid", WVALID, 1'b1);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("abort_wvalid", WVALID, 1'b0);
    check("abort_wd_ready", wd_ready, 1'b0);
    check("abort_awvalid", AWVALID, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    WREADY = 1'b0; wd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      #1;
      check("abort_no_done", done_valid, 1'b0);
    end

    // Single-beat burst after the abort: WLAST on the first beat.
    request(32'h5000, 4'd0, 8'h33, 4'hC);
    finish_burst(32'h5000, 4'd0, 8'h33, 4'hC, 2, 1'b0, 1, 2'b00);

`ifdef AXI_WR_BRESP_TIMEOUT_EN
    request(32'h6000, 4'd1, 8'h44, 4'hF);
    finish_burst(32'h6000, 4'd1, 8'h44, 4'hF, 0, 1'b0, -1, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_write_master.md
AXI_BURST_WRITE_MASTER -- requirements
Module: axi_burst_write_master
Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI write-data width (32/64/128).
REQ-002 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-003 SHALL have parameter ID_W, default 8, AXI ID width.
REQ-004 SHALL have port ACLK  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port ARESETn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  burst request present.
REQ-007 SHALL have port req_ready  out  1  request accepted this cycle.
REQ-008 SHALL have port req_addr  in  ADDR_W  burst start address.
REQ-009 SHALL have port req_len  in  4  beats minus one (0-15).
REQ-010 SHALL have port req_id  in  ID_W  transaction ID.
REQ-011 SHALL have port req_strb  in  DATA_W/8  byte strobe applied to every beat.
REQ-012 SHALL have port wd_data  in  DATA_W  beat data from client.
REQ-013 SHALL have port wd_valid  in  1  client beat available.
REQ-014 SHALL have port wd_ready  out  1  client beat consumed.
REQ-015 SHALL have port rd_busy  in  1  read master active, blocks new request.
REQ-016 SHALL have port done_valid  out  1  one-cycle burst-complete pulse.
REQ-017 SHALL have port done_resp  out  2  final response code.
REQ-018 SHALL have port AWID  out  ID_W  write address ID.
REQ-019 SHALL have port AWADDR  out  ADDR_W  burst address.
REQ-020 SHALL have port AWLEN  out  4  burst length minus one.
REQ-021 SHALL have port AWSIZE  out  3  constant log2(DATA_W/8).
REQ-022 SHALL have port AWBURST  out  2  constant 2'b01 (INCR).
REQ-023 SHALL have port AWVALID  out  1  address valid.
REQ-024 SHALL have port AWREADY  in  1  address accepted.
REQ-025 SHALL have port WDATA  out  DATA_W  write data.
REQ-026 SHALL have port WSTRB  out  DATA_W/8  write strobe.
REQ-027 SHALL have port WLAST  out  1  final beat.
REQ-028 SHALL have port WVALID  out  1  data valid.
REQ-029 SHALL have port WREADY  in  1  data accepted.
REQ-030 SHALL have port BRESP  in  2  slave response.
REQ-031 SHALL have port BVALID  in  1  response valid.
REQ-032 SHALL have port BREADY  out  1  response accepted.
Function
REQ-033 SHALL use FSM IDLE->ADDR->DATA->RESP->IDLE; req_ready=1 only in IDLE with rd_busy=0; accept on req_valid&req_ready, latch addr/len/id/strb, beat counter=req_len, go ADDR.
REQ-034 SHALL in ADDR drive AWVALID=1 with latched fields held stable until AWREADY; AWVALID&AWREADY -> DATA next cycle; AWVALID never retracted before handshake.
REQ-035 SHALL in DATA drive WVALID=wd_valid, wd_ready=WREADY, WDATA=wd_data (zero-latency passthrough), WSTRB=latched strb; each WVALID&WREADY decrements counter; WLAST=1 when counter==0.
REQ-036 SHALL transition DATA->RESP on WLAST&WVALID&WREADY; exactly req_len+1 beats; req_len=0 gives single beat with WLAST on first beat.
REQ-037 SHALL in RESP drive BREADY=1; BVALID -> IDLE, done_valid=1 in following cycle with done_resp=BRESP (registered); new request acceptable in that same cycle.
REQ-038 SHALL drive AWVALID, WVALID, BREADY, wd_ready=0 and AWID/AWADDR/AWLEN/WDATA/WSTRB=0 outside their states; req_valid/rd_busy changes after acceptance ignored until IDLE.
REQ-039 SHALL ignore AWREADY/WREADY/BVALID in states not expecting them; wd_valid low stalls beats indefinitely.
Reset
REQ-040 SHALL on ARESETn=0 at a rising edge (incl. mid-burst) enter IDLE, clear counter/latches, drive all valids, ready outputs except req_ready, done_valid, done_resp=0; no done pulse for aborted burst.
Configuration
REQ-041 SHALL, with AXI_WR_BRESP_TIMEOUT_EN defined, count RESP cycles and after WR_TIMEOUT_CYC cycles without BVALID return to IDLE with done_valid=1, done_resp=2'b10 (SLVERR).
REQ-042 SHALL, without AXI_WR_BRESP_TIMEOUT_EN, wait in RESP indefinitely with no timeout counter logic.
Structure
REQ-043 SHALL take state enum, burst encodings (INCR=2'b01), response codes and WR_TIMEOUT_CYC=256 from shared package axi_wr_pkg; sub-module wr_beat_counter (load/decrement/last flag) is natural.
Verification
REQ-044 SHALL cover: req_len=3, addr 0x1000, AWREADY=1 -> AWLEN=3, 4 W beats, WLAST on beat 4 only, BRESP=0 -> done_valid one cycle, done_resp=0.
REQ-045 SHALL cover: AWREADY held low 5 cycles, then WREADY toggling every other cycle -> AWADDR stable during wait, no beat lost or duplicated.
REQ-046 SHALL cover: rd_busy=1 with req_valid=1 -> req_ready=0, AWVALID=0; rd_busy drops -> accepted next cycle; ARESETn low mid-DATA -> IDLE, no done pulse.
REQ-047 SHALL cover: AXI_WR_BRESP_TIMEOUT_EN defined, BVALID never asserted -> done_valid after 256 RESP cycles, done_resp=2'b10; DATA_W=64 build -> AWSIZE=3'b011.
